decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Registered RV32I instruction-decode stage with a valid/ready handshake on both sides and a DEPTH-entry output queue.
- Each accepted instruction gets a control-ROM index and a strict illegal-instruction flag.
- The instruction, PC, index and flag are queued for the execute-side consumer.
- Sits between fetch and the control ROM/execute stage. Adds backpressure, flush and illegal-instruction accounting to the purely combinational decode.

Parameters:
ROM_W, 6, control-ROM index width; must be >= 6.
DEPTH, 2, output queue entries; power of two, >= 2.
PC_W, 32, PC width carried alongside each instruction.
CNT_W, 16, illegal-instruction counter width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage accepts the instruction this cycle.
in_instr  in  32  raw instruction word.
in_pc  in  PC_W  PC of in_instr.
flush  in  1  discard all queued entries and any same-cycle input.
out_valid  out  1  head entry is valid.
out_ready  in  1  consumer takes the head entry this cycle.
out_rom_idx  out  ROM_W  control-ROM index of the head entry.
out_illegal  out  1  head entry is illegal.
out_instr  out  32  head raw instruction.
out_pc  out  PC_W  head PC.
illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async assert, sync-released by the environment): queue empty; out_valid=0; count=0; illegal_count=0.
- Head payload outputs read as 0 while empty.
- in_ready = (count < DEPTH) && !flush. It does not depend on out_ready, so there is no bypass when full.
- Push = in_valid && in_ready. Pop = out_valid && out_ready && !flush.
- Latency: an instruction pushed at edge N is at the head (out_valid=1) in the cycle after N if the queue was empty. Otherwise FIFO order is preserved.
- Simultaneous push and pop: count unchanged. Write and read pointers wrap modulo DEPTH.
- Flush: at the edge, count, read pointer and write pointer go to 0. Any same-cycle input is not accepted and no pop is counted. illegal_count is not cleared.
- Decode (combinational, before the queue register):
  - Recognised: R-type, I-type ALU, LOAD (LB/LH/LW/LBU/LHU), STORE (SB/SH/SW), BRANCH (6), LUI, AUIPC, JAL, JALR.
  - R-type funct7 must be 0000000, or 0100000 only for SUB/SRA.
  - SLLI/SRLI need funct7=0000000; SRAI needs 0100000.
  - JALR needs funct3=000.
  - Any other opcode, funct3 or funct7 combination: out_illegal=1 and rom_idx = NOPE.
  - instr = 0x00000013 decodes to ADDI and is legal.
- illegal_count increments by 1 on each push with illegal=1 and saturates at all-ones.
- Reset asserted mid-operation: all state cleared immediately; no partial entries.
- A held-valid input while in_ready=0 must not be lost. Fetch must hold it stable until accepted; the stage samples only on push.

Optional Feature:
- Macro RV32M_DECODE_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 000..111) to their own ROM indices, legal.
- Undefined: those encodings are illegal (NOPE, out_illegal=1, counted).

Decomposition:
- Shared package/include holds:
  - opcode, funct3 and funct7 constants;
  - ROM index constants for all RV32I ops, NOPE and the eight M ops;
  - ROM_W minimum check.
- One sub-module, decode_classify: combinational instr -> {rom_idx, illegal}, with the M decode inside an RV32M_DECODE_EN guard.
- The queue, handshake and counter stay in decode_queue.

Test Plan:
- Reset, then push 0x00A00093 (ADDI) with out_ready=1 -> out_valid next cycle, rom_idx=ADDI, illegal=0, correct PC; steady one per cycle.
- out_ready=0, push 3 instrs with DEPTH=2 -> in_ready=0 after two pushes; the third is held and accepted once out_ready=1; FIFO order and PCs intact.
- Push 0xFFFFFFFF, 0x40001033 (funct3=001 with funct7=0100000), 0x00001067 (JALR funct3=001) -> each illegal=1, rom_idx=NOPE; illegal_count=3.
- Queue holds 2 entries, flush with in_valid=1 -> next cycle out_valid=0, input not accepted, illegal_count unchanged.
- Push 0x02B50533 (MUL) -> MUL index and legal with RV32M_DECODE_EN; illegal and counted without it.
- Preload illegal_count to near max (CNT_W=2), push 5 illegals -> saturates at 3; assert rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields and control-ROM indices.
// The M-extension indices are always defined; decode_classify only emits them under RV32M_DECODE_EN.
package decode_queue_pkg;

  localparam int ROM_W_MIN = 6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef logic [5:0] rom_idx_t;

  localparam rom_idx_t IDX_NOPE  = 6'd0;
  localparam rom_idx_t IDX_LUI   = 6'd1;
  localparam rom_idx_t IDX_AUIPC = 6'd2;
  localparam rom_idx_t IDX_JAL   = 6'd3;
  localparam rom_idx_t IDX_JALR  = 6'd4;
  localparam rom_idx_t IDX_BEQ   = 6'd5;
  localparam rom_idx_t IDX_BNE   = 6'd6;
  localparam rom_idx_t IDX_BLT   = 6'd7;
  localparam rom_idx_t IDX_BGE   = 6'd8;
  localparam rom_idx_t IDX_BLTU  = 6'd9;
  localparam rom_idx_t IDX_BGEU  = 6'd10;
  localparam rom_idx_t IDX_LB    = 6'd11;
  localparam rom_idx_t IDX_LH    = 6'd12;
  localparam rom_idx_t IDX_LW    = 6'd13;
  localparam rom_idx_t IDX_LBU   = 6'd14;
  localparam rom_idx_t IDX_LHU   = 6'd15;
  localparam rom_idx_t IDX_SB    = 6'd16;
  localparam rom_idx_t IDX_SH    = 6'd17;
  localparam rom_idx_t IDX_SW    = 6'd18;
  localparam rom_idx_t IDX_ADDI  = 6'd19;
  localparam rom_idx_t IDX_SLTI  = 6'd20;
  localparam rom_idx_t IDX_SLTIU = 6'd21;
  localparam rom_idx_t IDX_XORI  = 6'd22;
  localparam rom_idx_t IDX_ORI   = 6'd23;
  localparam rom_idx_t IDX_ANDI  = 6'd24;
  localparam rom_idx_t IDX_SLLI  = 6'd25;
  localparam rom_idx_t IDX_SRLI  = 6'd26;
  localparam rom_idx_t IDX_SRAI  = 6'd27;
  localparam rom_idx_t IDX_ADD   = 6'd28;
  localparam rom_idx_t IDX_SUB   = 6'd29;
  localparam rom_idx_t IDX_SLL   = 6'd30;
  localparam rom_idx_t IDX_SLT   = 6'd31;
  localparam rom_idx_t IDX_SLTU  = 6'd32;
  localparam rom_idx_t IDX_XOR   = 6'd33;
  localparam rom_idx_t IDX_SRL   = 6'd34;
  localparam rom_idx_t IDX_SRA   = 6'd35;
  localparam rom_idx_t IDX_OR    = 6'd36;
  localparam rom_idx_t IDX_AND   = 6'd37;
  // MUL..REMU occupy IDX_MUL + funct3, in funct3 order
  localparam rom_idx_t IDX_MUL    = 6'd38;
  localparam rom_idx_t IDX_MULH   = 6'd39;
  localparam rom_idx_t IDX_MULHSU = 6'd40;
  localparam rom_idx_t IDX_MULHU  = 6'd41;
  localparam rom_idx_t IDX_DIV    = 6'd42;
  localparam rom_idx_t IDX_DIVU   = 6'd43;
  localparam rom_idx_t IDX_REM    = 6'd44;
  localparam rom_idx_t IDX_REMU   = 6'd45;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
// master = surrounding pipeline, slave = decode_queue.
interface decode_queue_if #(
  parameter int PC_W  = 32,
  parameter int ROM_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [PC_W-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ROM_W-1:0] out_rom_idx;
  logic             out_illegal;
  logic [31:0]      out_instr;
  logic [PC_W-1:0]  out_pc;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_rom_idx,
    input  out_illegal, out_instr, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_rom_idx,
    output out_illegal, out_instr, out_pc
  );
endinterface

// File: rtl/decode_queue_classify.sv
// Combinational RV32I classifier: opcode/funct3/funct7 -> ROM index + illegal flag.
// RV32M_DECODE_EN adds the MUL/DIV group on OP_REG with funct7=0000001.
module decode_classify
  import decode_queue_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output rom_idx_t   rom_idx_o,
  output logic       illegal_o
);
  rom_idx_t idx;
  logic     ok;

  always_comb begin
    idx = IDX_NOPE;
    ok  = 1'b0;
    unique case (opcode_i)
      OP_LUI:   begin idx = IDX_LUI;   ok = 1'b1; end
      OP_AUIPC: begin idx = IDX_AUIPC; ok = 1'b1; end
      OP_JAL:   begin idx = IDX_JAL;   ok = 1'b1; end
      OP_JALR: begin
        if (funct3_i == 3'b000) begin
          idx = IDX_JALR;
          ok  = 1'b1;
        end
      end
      OP_BRANCH: begin
        ok = 1'b1;
        unique case (funct3_i)
          3'b000:  idx = IDX_BEQ;
          3'b001:  idx = IDX_BNE;
          3'b100:  idx = IDX_BLT;
          3'b101:  idx = IDX_BGE;
          3'b110:  idx = IDX_BLTU;
          3'b111:  idx = IDX_BGEU;
          default: ok  = 1'b0;
        endcase
      end
      OP_LOAD: begin
        ok = 1'b1;
        unique case (funct3_i)
          3'b000:  idx = IDX_LB;
          3'b001:  idx = IDX_LH;
          3'b010:  idx = IDX_LW;
          3'b100:  idx = IDX_LBU;
          3'b101:  idx = IDX_LHU;
          default: ok  = 1'b0;
        endcase
      end
      OP_STORE: begin
        ok = 1'b1;
        unique case (funct3_i)
          3'b000:  idx = IDX_SB;
          3'b001:  idx = IDX_SH;
          3'b010:  idx = IDX_SW;
          default: ok  = 1'b0;
        endcase
      end
      OP_IMM: begin
        ok = 1'b1;
        unique case (funct3_i)
          F3_ADD:  idx = IDX_ADDI;
          F3_SLT:  idx = IDX_SLTI;
          F3_SLTU: idx = IDX_SLTIU;
          F3_XOR:  idx = IDX_XORI;
          F3_OR:   idx = IDX_ORI;
          F3_AND:  idx = IDX_ANDI;
          F3_SLL: begin
            if (funct7_i == F7_BASE) idx = IDX_SLLI;
            else                     ok  = 1'b0;
          end
          default: begin
            if (funct7_i == F7_BASE)     idx = IDX_SRLI;
            else if (funct7_i == F7_ALT) idx = IDX_SRAI;
            else                         ok  = 1'b0;
          end
        endcase
      end
      OP_REG: begin
        if (funct7_i == F7_BASE) begin
          ok = 1'b1;
          unique case (funct3_i)
            F3_ADD:  idx = IDX_ADD;
            F3_SLL:  idx = IDX_SLL;
            F3_SLT:  idx = IDX_SLT;
            F3_SLTU: idx = IDX_SLTU;
            F3_XOR:  idx = IDX_XOR;
            F3_SR:   idx = IDX_SRL;
            F3_OR:   idx = IDX_OR;
            default: idx = IDX_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == F3_ADD) begin
            idx = IDX_SUB;
            ok  = 1'b1;
          end else if (funct3_i == F3_SR) begin
            idx = IDX_SRA;
            ok  = 1'b1;
          end
        end
`ifdef RV32M_DECODE_EN
        else if (funct7_i == F7_MULDIV) begin
          idx = IDX_MUL + rom_idx_t'(funct3_i);
          ok  = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  assign rom_idx_o = idx;
  assign illegal_o = !ok;
endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: classify on push, DEPTH-entry FIFO toward execute.
// Optional M-extension decode via RV32M_DECODE_EN (see decode_classify).
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int ROM_W = 6,
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_queue_if.slave    dq,
  output logic [CNT_W-1:0] illegal_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (ROM_W < ROM_W_MIN) begin : g_rom_w_chk
    $error("decode_queue: ROM_W must be >= 6");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("decode_queue: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic [31:0]      instr_q [DEPTH];
  logic [PC_W-1:0]  pc_q    [DEPTH];
  logic [ROM_W-1:0] idx_q   [DEPTH];
  logic [DEPTH-1:0] ill_q;

  rom_idx_t cls_idx;
  logic     cls_ill;
  logic     push, pop;

  decode_classify u_classify (
    .opcode_i  (dq.in_instr[6:0]),
    .funct3_i  (dq.in_instr[14:12]),
    .funct7_i  (dq.in_instr[31:25]),
    .rom_idx_o (cls_idx),
    .illegal_o (cls_ill)
  );

  // No bypass: a full queue refuses input even if the head leaves this cycle
  assign dq.in_ready  = (cnt_q < CW'(DEPTH)) && !dq.flush;
  assign dq.out_valid = (cnt_q != '0);

  assign push = dq.in_valid && dq.in_ready;
  assign pop  = dq.out_valid && dq.out_ready && !dq.flush;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (push && cls_ill && ill_cnt_q != '1)
      ill_cnt_d = ill_cnt_q + CNT_W'(1);
    if (dq.flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ill_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        idx_q[i]   <= '0;
      end
      ill_q <= '0;
    end else if (push) begin
      instr_q[wptr_q] <= dq.in_instr;
      pc_q[wptr_q]    <= dq.in_pc;
      idx_q[wptr_q]   <= ROM_W'(cls_idx);
      ill_q[wptr_q]   <= cls_ill;
    end
  end

  assign dq.out_instr   = dq.out_valid ? instr_q[rptr_q] : '0;
  assign dq.out_pc      = dq.out_valid ? pc_q[rptr_q]    : '0;
  assign dq.out_rom_idx = dq.out_valid ? idx_q[rptr_q]   : '0;
  assign dq.out_illegal = dq.out_valid && ill_q[rptr_q];
  assign illegal_count  = ill_cnt_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, CNT_W=2 so saturation is reachable).
// Expected MUL decode follows RV32M_DECODE_EN.
module tb_decode_queue;
  import decode_queue_pkg::*;

  logic clk;
  logic rst_n;
  logic [1:0] illegal_count;
  int total;
  int bad;

  decode_queue_if #(.PC_W(32), .ROM_W(6)) dq ();

  decode_queue #(
    .ROM_W(6), .DEPTH(2), .PC_W(32), .CNT_W(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dq            (dq),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    dq.in_valid = v;
    dq.in_instr = ins;
    dq.in_pc    = pc;
  endtask

  task automatic head(input string tag, input logic [31:0] ins,
                      input logic [31:0] pc, input rom_idx_t idx,
                      input logic ill);
    chk({tag, ".valid"}, 64'(dq.out_valid), 64'(1'b1));
    chk({tag, ".instr"}, 64'(dq.out_instr), 64'(ins));
    chk({tag, ".pc"}, 64'(dq.out_pc), 64'(pc));
    chk({tag, ".idx"}, 64'(dq.out_rom_idx), 64'(idx));
    chk({tag, ".ill"}, 64'(dq.out_illegal), 64'(ill));
  endtask

  rom_idx_t mul_idx;
  logic     mul_ill;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dq.flush     = 1'b0;
    dq.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
`ifdef RV32M_DECODE_EN
    mul_idx = IDX_MUL;
    mul_ill = 1'b0;
`else
    mul_idx = IDX_NOPE;
    mul_ill = 1'b1;
`endif

    #2;
    chk("rst.valid", 64'(dq.out_valid), 64'(1'b0));
    chk("rst.pc", 64'(dq.out_pc), 64'h0);
    chk("rst.cnt", 64'(illegal_count), 64'h0);
    chk("rst.ready", 64'(dq.in_ready), 64'(1'b1));
    step();
    step();
    rst_n = 1'b1;
    step();

    // streaming, one per cycle
    dq.out_ready = 1'b1;
    drive(1'b1, 32'h00A00093, 32'h100);
    step();
    head("t1a", 32'h00A00093, 32'h100, IDX_ADDI, 1'b0);
    drive(1'b1, 32'h00000013, 32'h104);
    step();
    head("t1b", 32'h00000013, 32'h104, IDX_ADDI, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t1.empty", 64'(dq.out_valid), 64'(1'b0));
    chk("t1.zpc", 64'(dq.out_pc), 64'h0);

    // backpressure, third instruction held
    dq.out_ready = 1'b0;
    drive(1'b1, 32'h00B00113, 32'h200);
    step();
    drive(1'b1, 32'h002081B3, 32'h204);
    chk("t2.rdy1", 64'(dq.in_ready), 64'(1'b1));
    step();
    chk("t2.full", 64'(dq.in_ready), 64'(1'b0));
    drive(1'b1, 32'h40208233, 32'h208);
    step();
    chk("t2.held", 64'(dq.in_ready), 64'(1'b0));
    head("t2a", 32'h00B00113, 32'h200, IDX_ADDI, 1'b0);
    dq.out_ready = 1'b1;
    step();
    head("t2b", 32'h002081B3, 32'h204, IDX_ADD, 1'b0);
    step();
    head("t2c", 32'h40208233, 32'h208, IDX_SUB, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("t2.empty", 64'(dq.out_valid), 64'(1'b0));

    // flush with a same-cycle illegal input
    dq.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h400);
    step();
    drive(1'b1, 32'h00200093, 32'h404);
    step();
    chk("t4.full", 64'(dq.in_ready), 64'(1'b0));
    dq.flush = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 32'h408);
    dq.out_ready = 1'b1;
    #1;
    chk("t4.rdyfl", 64'(dq.in_ready), 64'(1'b0));
    step();
    dq.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("t4.valid", 64'(dq.out_valid), 64'(1'b0));
    chk("t4.cnt", 64'(illegal_count), 64'h0);
    chk("t4.ready", 64'(dq.in_ready), 64'(1'b1));

    // illegal encodings and counting
    drive(1'b1, 32'hFFFFFFFF, 32'h300);
    step();
    head("t3a", 32'hFFFFFFFF, 32'h300, IDX_NOPE, 1'b1);
    chk("t3a.cnt", 64'(illegal_count), 64'd1);
    drive(1'b1, 32'h40001033, 32'h304);
    step();
    head("t3b", 32'h40001033, 32'h304, IDX_NOPE, 1'b1);
    chk("t3b.cnt", 64'(illegal_count), 64'd2);
    drive(1'b1, 32'h00001067, 32'h308);
    step();
    head("t3c", 32'h00001067, 32'h308, IDX_NOPE, 1'b1);
    chk("t3c.cnt", 64'(illegal_count), 64'd3);
    drive(1'b1, 32'h02B50533, 32'h30C);
    step();
    head("mul", 32'h02B50533, 32'h30C, mul_idx, mul_ill);
    drive(1'b1, 32'hFFFFFFFF, 32'h310);
    step();
    drive(1'b1, 32'h00001067, 32'h314);
    step();
    chk("sat.cnt", 64'(illegal_count), 64'd3);
    head("sat", 32'h00001067, 32'h314, IDX_NOPE, 1'b1);

    // async reset in the middle of a full queue
    dq.out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 32'h500);
    step();
    step();
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", 64'(dq.out_valid), 64'(1'b0));
    chk("mrst.instr", 64'(dq.out_instr), 64'h0);
    chk("mrst.pc", 64'(dq.out_pc), 64'h0);
    chk("mrst.cnt", 64'(illegal_count), 64'h0);
    chk("mrst.ready", 64'(dq.in_ready), 64'(1'b1));
    step();
    rst_n = 1'b1;
    step();
    chk("post.valid", 64'(dq.out_valid), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
